// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: RV32IM execute stage with forwarding, single-cycle multiply, restoring divider and EX/MEM register
module ex_stage_muldiv #(
  parameter int XLEN = 32,
  parameter int DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [3:0]      ctrl,
  input  logic            mem_to_reg,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic            stall,
  output logic            valid_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic [2:0]      func3_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            mem_to_reg_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;
  logic [XLEN-1:0] a, rs2_f, b, alu_res, a_mag, b_mag, q_q, r_q, d_q, quo, rem;
  logic [XLEN:0] r_sh, diff;
  logic signed [2*XLEN+1:0] ma, mb, prod;
  logic [DIV_CNT_W-1:0] cnt;
  logic [4:0] rd_q;
  logic [2:0] func3_q;
  logic rw_q, m2r_q, neg_q, neg_r;
  logic is_mem, m_ext, sub, div_op, div_start, sgn, a_neg, b_neg, div_zero, div_ovf, special, live;
  assign a = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs1) ? exmem_result :
             (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1) ? memwb_result : rs1_val;
  assign rs2_f = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs2) ? exmem_result :
                 (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2) ? memwb_result : rs2_val;
  assign b = ctrl[0] ? imm : rs2_f;
  assign is_mem = ctrl[2] | ctrl[3];
  assign m_ext = !ctrl[0] && func7 == 7'b0000001;
  assign sub = !ctrl[0] && func7 == 7'b0100000;
  assign div_op = m_ext && func3[2] && !is_mem;
  assign div_start = div_op && in_valid;
  // One signed 66-bit multiplier covers all four variants by choosing how each operand extends
  assign ma = {{(XLEN+2){(func3 == 3'b001 || func3 == 3'b010) & a[XLEN-1]}}, a};
  assign mb = {{(XLEN+2){(func3 == 3'b001) & b[XLEN-1]}}, b};
  assign prod = ma * mb;
  assign sgn = ~func3[0];
  assign a_neg = sgn & a[XLEN-1];
  assign b_neg = sgn & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign div_zero = b == '0;
  assign div_ovf = sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
  assign special = div_zero | div_ovf;
  assign r_sh = {r_q, q_q[XLEN-1]};
  assign diff = r_sh - {1'b0, d_q};
  assign quo = neg_q ? -q_q : q_q;
  assign rem = neg_r ? -r_q : r_q;
  assign live = in_valid && !flush && !stall;
  always_comb begin
    alu_res = '0;
    if (is_mem) alu_res = a + imm;
    else if (m_ext) alu_res = func3[2] ? '0 : (func3 == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    else
      case (func3)
        3'b000: alu_res = sub ? a - b : a + b;
        3'b001: alu_res = a << b[4:0];
        3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        3'b011: alu_res = {{(XLEN-1){1'b0}}, a < b};
        3'b100: alu_res = a ^ b;
        3'b101: alu_res = func7[5] ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'b110: alu_res = a | b;
        default: alu_res = a & b;
      endcase
  end
  always_comb begin
    state_d = state;
    if (flush) state_d = IDLE;
    else if (state == IDLE) state_d = div_start ? (special ? DONE : BUSY) : IDLE;
    else if (state == BUSY) state_d = cnt == '0 ? DONE : BUSY;
    else state_d = IDLE;
    stall = !flush && ((state == IDLE && div_start) || state == BUSY);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rd_q <= '0;
      func3_q <= '0;
      rw_q <= 1'b0;
      m2r_q <= 1'b0;
      valid_out <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out <= '0;
      func3_out <= '0;
      reg_write_out <= 1'b0;
      mem_read_out <= 1'b0;
      mem_write_out <= 1'b0;
      mem_to_reg_out <= 1'b0;
    end else begin
      state <= state_d;
      // Special cases preload the final result with sign correction disabled
      if (state == IDLE && state_d != IDLE) begin
        cnt <= '1;
        q_q <= div_zero ? '1 : div_ovf ? {1'b1, {(XLEN-1){1'b0}}} : a_mag;
        r_q <= div_zero ? a : '0;
        d_q <= b_mag;
        neg_q <= !special && (a_neg ^ b_neg);
        neg_r <= !special && a_neg;
        rd_q <= rd;
        func3_q <= func3;
        rw_q <= ctrl[1];
        m2r_q <= mem_to_reg;
      end else if (state == BUSY) begin
        cnt <= cnt - DIV_CNT_W'(1);
        q_q <= {q_q[XLEN-2:0], !diff[XLEN]};
        r_q <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      end
      if (state == DONE && !flush) begin
        valid_out <= 1'b1;
        alu_result_out <= func3_q[1] ? rem : quo;
        store_data_out <= rs2_f;
        rd_out <= rd_q;
        func3_out <= func3_q;
        reg_write_out <= rw_q;
        mem_read_out <= 1'b0;
        mem_write_out <= 1'b0;
        mem_to_reg_out <= m2r_q;
      end else begin
        valid_out <= live;
        alu_result_out <= alu_res;
        store_data_out <= rs2_f;
        rd_out <= rd;
        func3_out <= func3;
        reg_write_out <= live & ctrl[1];
        mem_read_out <= live & ctrl[2];
        mem_write_out <= live & ctrl[3];
        mem_to_reg_out <= live & mem_to_reg;
      end
    end
  end
endmodule
